// File: rtl/vga_sync_pattern.sv
// vga_sync_pattern: 640x480@60 Hz raster counter with a built-in colour-bar /
// grayscale-ramp test pattern, used as the bring-up reference for display paths.
// Optional feature macro: VGA_TEST_PATTERN_EN. When it is undefined the pattern
// logic is compiled out and red/green/blue are held at 0, while sync, visible,
// column and row behave exactly the same.
// Timing defaults come from the VGA_MODE_* macros and fall back to the standard
// 640x480@60 mode when those macros are not supplied by the build.

`ifndef VGA_MODE_H_VISIBLE
`define VGA_MODE_H_VISIBLE 640
`endif
`ifndef VGA_MODE_H_FRONT
`define VGA_MODE_H_FRONT 16
`endif
`ifndef VGA_MODE_H_SYNC
`define VGA_MODE_H_SYNC 96
`endif
`ifndef VGA_MODE_H_BACK
`define VGA_MODE_H_BACK 48
`endif
`ifndef VGA_MODE_V_VISIBLE
`define VGA_MODE_V_VISIBLE 480
`endif
`ifndef VGA_MODE_V_FRONT
`define VGA_MODE_V_FRONT 10
`endif
`ifndef VGA_MODE_V_SYNC
`define VGA_MODE_V_SYNC 2
`endif
`ifndef VGA_MODE_V_BACK
`define VGA_MODE_V_BACK 33
`endif

module vga_sync_pattern #(
  parameter int H_VISIBLE = `VGA_MODE_H_VISIBLE,
  parameter int H_FRONT   = `VGA_MODE_H_FRONT,
  parameter int H_SYNC    = `VGA_MODE_H_SYNC,
  parameter int H_BACK    = `VGA_MODE_H_BACK,
  parameter int V_VISIBLE = `VGA_MODE_V_VISIBLE,
  parameter int V_FRONT   = `VGA_MODE_V_FRONT,
  parameter int V_SYNC    = `VGA_MODE_V_SYNC,
  parameter int V_BACK    = `VGA_MODE_V_BACK
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic visible,
  output logic hsync,
  output logic vsync,
  output logic [$clog2(H_VISIBLE+H_FRONT+H_SYNC+H_BACK)-1:0] column,
  output logic [$clog2(V_VISIBLE+V_FRONT+V_SYNC+V_BACK)-1:0] row,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int H_WHOLE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_WHOLE  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW       = $clog2(H_WHOLE);
  localparam int RW       = $clog2(V_WHOLE);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  // Raster position: column steps once per enabled clock, row steps at end of line,
  // both wrap together at the last pixel of the frame; reset overrides enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      column <= '0;
      row    <= '0;
    end else if (enable) begin
      if (column == CW'(H_WHOLE - 1)) begin
        column <= '0;
        if (row == RW'(V_WHOLE - 1)) begin
          row <= '0;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        column <= column + 1'b1;
      end
    end
  end

  // Same-cycle decode of visible area and active-low sync pulses from the counters.
  always_comb begin
    visible = (column < CW'(H_VISIBLE)) && (row < RW'(V_VISIBLE));
    hsync   = !((column >= CW'(HS_START)) && (column < CW'(HS_END)));
    vsync   = !((row >= RW'(VS_START)) && (row < RW'(VS_END)));
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_WIDTH = H_VISIBLE / 8;

  logic [2:0] bar;
  logic [3:0] ramp;

  // Upper half shows eight primary/secondary colour bars, lower half a gray ramp
  // taken from column[9:6]; everything outside the visible area is black.
  always_comb begin
    bar   = 3'(column / CW'(BAR_WIDTH));
    ramp  = 4'(column >> 6);
    red   = 4'h0;
    green = 4'h0;
    blue  = 4'h0;
    if (visible) begin
      if (row < RW'(V_VISIBLE / 2)) begin
        red   = bar[2] ? 4'hF : 4'h0;
        green = bar[1] ? 4'hF : 4'h0;
        blue  = bar[0] ? 4'hF : 4'h0;
      end else begin
        red   = ramp;
        green = ramp;
        blue  = ramp;
      end
    end
  end
`else
  // Pattern source compiled out: colour outputs stay black.
  always_comb begin
    red   = 4'h0;
    green = 4'h0;
    blue  = 4'h0;
  end
`endif

endmodule

// File: tb/tb_vga_sync_pattern.sv
// Testbench for vga_sync_pattern. Two instances share clock and stimulus: one with
// the default 640x480 timing (horizontal behaviour, colour bars, line wraps) and one
// with the default horizontal timing but a 7-line frame so that whole frames, vsync
// pulses and the grayscale half fit in a short run. Expected values come from a
// position-based model pushed into per-instance scoreboard queues.

module tb_vga_sync_pattern;

  localparam int HW      = 800;
  localparam int A_FRAME = HW * 525;
  localparam int B_FRAME = HW * 7;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       vis;
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  logic       vis_a, hs_a, vs_a;
  logic [9:0] col_a, row_a;
  logic [3:0] r_a, g_a, b_a;

  logic       vis_b, hs_b, vs_b;
  logic [9:0] col_b;
  logic [2:0] row_b;
  logic [3:0] r_b, g_b, b_b;

  int   tests = 0;
  int   fails = 0;
  int   p = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  vga_sync_pattern dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .visible(vis_a), .hsync(hs_a), .vsync(vs_a),
    .column(col_a), .row(row_a),
    .red(r_a), .green(g_a), .blue(b_a)
  );

  vga_sync_pattern #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable),
    .visible(vis_b), .hsync(hs_b), .vsync(vs_b),
    .column(col_b), .row(row_b),
    .red(r_b), .green(g_b), .blue(b_b)
  );

  // Reference: raster position derived from the linear pixel index since reset.
  function automatic exp_t model(input int pos, input int vvis, input int vfr,
                                 input int vsy, input int vbk);
    int   vwhole;
    int   pp;
    int   c;
    int   rw;
    int   bar;
    exp_t e;
    vwhole = vvis + vfr + vsy + vbk;
    pp     = pos % (HW * vwhole);
    c      = pp % HW;
    rw     = pp / HW;
    e.col  = 10'(c);
    e.row  = 10'(rw);
    e.vis  = (c < 640) && (rw < vvis);
    e.hs   = !((c >= 656) && (c < 752));
    e.vs   = !((rw >= vvis + vfr) && (rw < vvis + vfr + vsy));
    e.r    = 4'h0;
    e.g    = 4'h0;
    e.b    = 4'h0;
    if (PAT && e.vis) begin
      if (rw < vvis / 2) begin
        bar = c / 80;
        e.r = ((bar & 4) != 0) ? 4'hF : 4'h0;
        e.g = ((bar & 2) != 0) ? 4'hF : 4'h0;
        e.b = ((bar & 1) != 0) ? 4'hF : 4'h0;
      end else begin
        e.r = 4'((c / 64) % 16);
        e.g = e.r;
        e.b = e.r;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int expv);
    tests++;
    if (obs != expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic compareScoreboard();
    exp_t ea;
    exp_t eb;
    checkOutput("sb.depth", q_a.size() + q_b.size(), 2);
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    checkOutput("a.column",  int'(col_a), int'(ea.col));
    checkOutput("a.row",     int'(row_a), int'(ea.row));
    checkOutput("a.visible", int'(vis_a), int'(ea.vis));
    checkOutput("a.hsync",   int'(hs_a),  int'(ea.hs));
    checkOutput("a.vsync",   int'(vs_a),  int'(ea.vs));
    checkOutput("a.rgb",     int'({r_a, g_a, b_a}), int'({ea.r, ea.g, ea.b}));
    checkOutput("b.column",  int'(col_b), int'(eb.col));
    checkOutput("b.row",     int'(row_b), int'(eb.row));
    checkOutput("b.visible", int'(vis_b), int'(eb.vis));
    checkOutput("b.hsync",   int'(hs_b),  int'(eb.hs));
    checkOutput("b.vsync",   int'(vs_b),  int'(eb.vs));
    checkOutput("b.rgb",     int'({r_b, g_b, b_b}), int'({eb.r, eb.g, eb.b}));
  endtask

  task automatic applyStimulus(input logic rst, input logic en);
    reset  = rst;
    enable = en;
    if (rst) p = 0;
    else if (en) p++;
    q_a.push_back(model(p % A_FRAME, 480, 10, 2, 33));
    q_b.push_back(model(p % B_FRAME, 4, 1, 1, 1));
    @(posedge clk);
    #1;
    compareScoreboard();
  endtask

  initial begin
    int hs_cnt, hs_len, vs_cnt, vs_len, max_col, max_row;
    logic prev_hs, prev_vs;
    reset  = 1'b1;
    enable = 1'b0;

    applyStimulus(1'b1, 1'b0);
    checkOutput("reset.column",  int'(col_a), 0);
    checkOutput("reset.row",     int'(row_a), 0);
    checkOutput("reset.visible", int'(vis_a), 1);
    checkOutput("reset.hsync",   int'(hs_a), 1);
    checkOutput("reset.vsync",   int'(vs_a), 1);
    checkOutput("reset.rgb",     int'({r_a, g_a, b_a}), 0);

    hs_cnt = 0; hs_len = 0; vs_cnt = 0; vs_len = 0;
    max_col = 0; max_row = 0;
    prev_hs = hs_b;
    prev_vs = vs_b;
    for (int i = 0; i < 3 * B_FRAME; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (hs_b === 1'b0) hs_len++;
      if (prev_hs === 1'b1 && hs_b === 1'b0) hs_cnt++;
      if (prev_hs === 1'b0 && hs_b === 1'b1) begin
        checkOutput("hsync.width", hs_len, 96);
        hs_len = 0;
      end
      prev_hs = hs_b;
      if (vs_b === 1'b0) vs_len++;
      if (prev_vs === 1'b1 && vs_b === 1'b0) vs_cnt++;
      if (prev_vs === 1'b0 && vs_b === 1'b1) begin
        checkOutput("vsync.width", vs_len, 800);
        vs_len = 0;
      end
      prev_vs = vs_b;
      if (int'(col_b) > max_col) max_col = int'(col_b);
      if (int'(row_b) > max_row) max_row = int'(row_b);

      if (p == 80)   checkOutput("bar80.rgb",  int'({r_a, g_a, b_a}), PAT ? 12'h00F : 0);
      if (p == 560)  checkOutput("bar560.rgb", int'({r_a, g_a, b_a}), PAT ? 12'hFFF : 0);
      if (p == 1920) begin
        checkOutput("ramp320.rgb", int'({r_b, g_b, b_b}), PAT ? 12'h555 : 0);
        checkOutput("bar320.rgb",  int'({r_a, g_a, b_a}), PAT ? 12'hF00 : 0);
      end
      if (p == 640) begin
        checkOutput("vis640.visible", int'(vis_a), 0);
        checkOutput("vis640.rgb",     int'({r_a, g_a, b_a}), 0);
      end
      if (p == 3 * HW + 639) checkOutput("visLast.visible", int'(vis_b), 1);
      if (p == 4 * HW) begin
        checkOutput("visRow.visible", int'(vis_b), 0);
        checkOutput("visRow.rgb",     int'({r_b, g_b, b_b}), 0);
      end
      if (p == 655) checkOutput("hsync.655", int'(hs_a), 1);
      if (p == 656) checkOutput("hsync.656", int'(hs_a), 0);
      if (p == 751) checkOutput("hsync.751", int'(hs_a), 0);
      if (p == 752) checkOutput("hsync.752", int'(hs_a), 1);
      if (p == 5 * HW) checkOutput("vsync.start", int'(vs_b), 0);
      if (p == 6 * HW) checkOutput("vsync.end",   int'(vs_b), 1);
      if (p == 11 * HW - 1) checkOutput("wrap10.before", int'({row_a, col_a}), (10 << 10) | 799);
      if (p == 11 * HW)     checkOutput("wrap10.after",  int'({row_a, col_a}), (11 << 10));
      if (p == B_FRAME - 1) checkOutput("wrapFrame.before", int'({row_b, col_b}), (6 << 10) | 799);
      if (p == B_FRAME)     checkOutput("wrapFrame.after",  int'({row_b, col_b}), 0);
    end
    checkOutput("hsync.count", hs_cnt, 21);
    checkOutput("vsync.count", vs_cnt, 3);
    checkOutput("range.column", max_col, 799);
    checkOutput("range.row", max_row, 6);

    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("enable.col100", int'(col_a), 100);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("hold.column", int'(col_a), 100);
      checkOutput("hold.rgb", int'({r_a, g_a, b_a}), PAT ? 12'h00F : 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("resume.column", int'(col_a), 101);

    while (p < 3 * HW + 400) applyStimulus(1'b0, 1'b1);
    checkOutput("mid.position", int'({row_b, col_b}), (3 << 10) | 400);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midReset.column", int'(col_a), 0);
    checkOutput("midReset.row",    int'(row_a), 0);
    checkOutput("midReset.hsync",  int'(hs_a), 1);
    checkOutput("midReset.vsync",  int'(vs_b), 1);

    while (p < 5 * HW + 700) applyStimulus(1'b0, 1'b1);
    checkOutput("syncRegion.hsync", int'(hs_b), 0);
    checkOutput("syncRegion.vsync", int'(vs_b), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("resetWins.column", int'(col_b), 0);
    checkOutput("resetWins.row",    int'(row_b), 0);
    checkOutput("resetWins.hsync",  int'(hs_b), 1);
    checkOutput("resetWins.vsync",  int'(vs_b), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("afterReset.column", int'(col_a), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_pattern.md
# vga_sync_pattern

VGA timing generator with a built-in test-pattern colour source. It is a 640x480@60 Hz raster counter that produces hsync, vsync, visible, column and row. It also produces 4-bit RGB for a fixed colour-bar/ramp pattern. It sits between the pixel-clock domain and the board DAC pins and serves as the bring-up reference for any display path.

## Interface
Parameters (defaults come from the codebase VGA_MODE_* macros):
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch (H_WHOLE = 800)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch (V_WHOLE = 525)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- enable  in  1  advance raster when high; hold all state when low
- visible  out  1  high when column < H_VISIBLE and row < V_VISIBLE
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- column  out  $clog2(H_WHOLE)=10  current pixel x
- row  out  $clog2(V_WHOLE)=10  current line y
- red, green, blue  out  4 each  pattern colour

One clock; reset is synchronous and active-high.

## Operation
- column and row are registered counters.
- When enable is high, column increments each cycle.
- At H_WHOLE-1, column wraps to 0 and row increments.
- At row V_WHOLE-1 together with column H_WHOLE-1, both wrap to 0.
- enable low: column and row hold, and so do all outputs derived from them.
- hsync is 0 iff H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC, i.e. columns 656..751.
- vsync is 0 iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC, i.e. rows 490..491.
- Pattern, computed combinationally from column/row:
  - For row < 240: eight vertical bars, 80 px each, bar = column/80 (0..7). red = bar[2]?4'hF:0, green = bar[1]?4'hF:0, blue = bar[0]?4'hF:0.
  - For 240 <= row < 480: grayscale ramp with red = green = blue = column[9:6] (values 0..9).
- RGB is forced to 0 whenever visible is 0.
- Counter arithmetic is unsigned, 10-bit. Compares use full width, and no counter value >= H_WHOLE or >= V_WHOLE is ever produced.

## Timing
- Reset values: column=0, row=0, visible=1, hsync=1, vsync=1, red=4'hF? No: at column 0 bar 0 gives red=0, green=0, blue=0.
- visible, hsync, vsync and RGB are combinational decodes of the column/row registers. They have zero latency relative to column/row, i.e. they are valid in the same cycle.
- One column step per enabled clock.
- Line period: 800 enabled cycles.
- Frame period: 420 000 enabled cycles.
- Reset asserted mid-frame: on the next clk edge, the counters go to 0/0 regardless of enable.
- If reset and enable are both high, reset wins.
- hsync asserts at the same edge on which column becomes 656 and deasserts at the edge on which column becomes 752.

## Configuration
- Macro VGA_TEST_PATTERN_EN.
- Defined: red/green/blue carry the pattern described above, gated by visible.
- Not defined: the pattern logic is compiled out and red/green/blue are constant 0. The sync, visible, column and row behaviour is unchanged.

## Test plan
- Reset then 3 frames with enable=1 (1 260 000 clocks): column sweeps 0..799 and row sweeps 0..524 with no out-of-range values. Exactly 1575 hsync pulses of 96 cycles each occur, and exactly 3 vsync pulses of 1600 cycles each.
- Line wrap: at column=799, row=10, the next clock gives column=0, row=11. At column=799, row=524, the next clock gives column=0, row=0.
- Visible boundary: (639,479) gives visible=1; (640,0) and (0,480) give visible=0 with RGB=0.
- Pattern: (0,0) gives RGB 0/0/0; (80,0) gives 0/0/F; (560,0) gives F/F/F; (320,300) gives 5/5/5 (column[9:6] = 5).
- Enable: hold enable=0 for 50 cycles at column=100; column stays 100 and the outputs are stable. Re-enable and column reaches 101 on the next clock.
- Mid-frame reset: reset=1 for one cycle at (400,300), then column=0, row=0, hsync=1, vsync=1. Also applies with enable=0.
